// File: rtl/experiment_pkg.sv
// Shared types, constants and helper functions for the experiment driver slice.
package experiment_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CAPTURE,
        DONE
    } drv_state_t;

    // Galois LFSR for x^32+x^22+x^2+x+1, and the matching MISR feedback taps (bits 31,21,1,0).
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] MISR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] value);
        return value[0] ? ((value >> 1) ^ LFSR_POLY) : (value >> 1);
    endfunction

    function automatic logic [31:0] nonzero_seed(input logic [31:0] value);
        return (value == 32'h0) ? 32'h1 : value;
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] fold);
        return {sig[30:0], ^(sig & MISR_TAPS)} ^ fold;
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] value, input int unsigned amount);
        int unsigned s;
        s = amount % 32;
        return (value << s) | (value >> (32 - s));
    endfunction

endpackage

// File: rtl/lfsr32.sv
// Seedable 32-bit Galois LFSR with load and step enables; a zero seed is forced to 1.
module lfsr32
    import experiment_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] value
);

    localparam logic [31:0] RESET_VALUE = nonzero_seed(SEED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= RESET_VALUE;
        end else if (load) begin
            value <= nonzero_seed(load_value);
        end else if (step) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/experiment_driver.sv
// Drives LFSR operands into an experiment block and folds its results into a MISR signature.
// Build option: EXPERIMENT_DRIVER_CONTINUOUS_EN keeps batching while start stays high.
module experiment_driver
    import experiment_pkg::*;
#(
    parameter int unsigned FRAME_COUNT   = 16,
    parameter int unsigned OPERAND_COUNT = 2,
    parameter int unsigned OPERAND_WIDTH = 32,
    parameter int unsigned RESULT_COUNT  = 3,
    parameter int unsigned RESULT_WIDTH  = 32,
    parameter int unsigned LATENCY       = 4,
    parameter logic [31:0] LFSR_SEED     = 32'h0000_0001
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic                                           seed_load,
    input  logic [31:0]                                    seed,
    output logic                                           busy,
    output logic                                           done,
    output logic [$clog2(FRAME_COUNT+1)-1:0]               frame_idx,
    output logic [31:0]                                    signature,
    output logic [OPERAND_COUNT-1:0][OPERAND_WIDTH-1:0]    operands,
    input  logic [RESULT_COUNT-1:0][RESULT_WIDTH-1:0]      results
);

    localparam int unsigned IDX_W = $clog2(FRAME_COUNT + 1);
    localparam int unsigned CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    drv_state_t                                  state;
    logic [CNT_W-1:0]                            wait_cnt;
    logic [31:0]                                 lfsr_value;
    logic                                        lfsr_load;
    logic                                        lfsr_step_en;
    logic [OPERAND_COUNT-1:0][OPERAND_WIDTH-1:0] next_operands;
    logic [31:0]                                 fold;

    // seed_load only matters in IDLE and wins over start there.
    assign lfsr_load    = (state == IDLE) && seed_load;
    assign lfsr_step_en = (state == DRIVE);

    lfsr32 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .step       (lfsr_step_en),
        .load       (lfsr_load),
        .load_value (seed),
        .value      (lfsr_value)
    );

    always_comb begin
        next_operands = '0;
        for (int unsigned k = 0; k < OPERAND_COUNT; k++) begin
            next_operands[k] = OPERAND_WIDTH'(rotl32(lfsr_value, 8 * k));
        end
    end

    always_comb begin
        fold = '0;
        for (int unsigned j = 0; j < RESULT_COUNT; j++) begin
            fold = fold ^ 32'(results[j]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_idx <= '0;
            signature <= '0;
            operands  <= '0;
            wait_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !seed_load) begin
                        state     <= DRIVE;
                        busy      <= 1'b1;
                        frame_idx <= '0;
                        signature <= '0;
                    end
                end
                DRIVE: begin
                    operands <= next_operands;
                    wait_cnt <= CNT_W'(LATENCY);
                    state    <= (LATENCY > 0) ? WAIT : CAPTURE;
                end
                WAIT: begin
                    // Leaving at count 1 gives exactly LATENCY cycles in WAIT.
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (wait_cnt <= CNT_W'(1)) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    signature <= misr_step(signature, fold);
                    frame_idx <= frame_idx + IDX_W'(1);
                    if (32'(frame_idx) + 32'd1 < FRAME_COUNT) begin
                        state <= DRIVE;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
`ifdef EXPERIMENT_DRIVER_CONTINUOUS_EN
                    if (start) begin
                        state     <= DRIVE;
                        frame_idx <= '0;
                        signature <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/experiment_driver.md
Name: experiment_driver

Overview:
- Drives the operand bus of an experiment block and captures its result bus, which makes it the opposite end of the operands/results interface.
- On `start`, it runs FRAME_COUNT frames. Per frame it:
  - drives pseudo-random operands from a 32-bit LFSR,
  - waits LATENCY cycles,
  - samples the results,
  - folds them into a 32-bit MISR signature.
- It sits between the measurement control logic and the experiment. It gives deterministic, repeatable switching activity for power runs, plus a single signature for functional checking.

Parameters:
- FRAME_COUNT, 16: frames per run; must be ≥1.
- OPERAND_COUNT, 2: operand words driven.
- OPERAND_WIDTH, 32: bits per operand word; 32 = packed {imag[31:16], real[15:0]}.
- RESULT_COUNT, 3: result words captured.
- RESULT_WIDTH, 32: bits per result word.
- LATENCY, 4: cycles between operand update and a valid result; ≥0.
- LFSR_SEED, 32'h0000_0001: LFSR value applied at reset.

Ports:
- `clk`  in  1  experiment clock.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  level; sampled in IDLE; starts a run.
- `seed_load`  in  1  loads `seed` into the LFSR; honoured only in IDLE.
- `seed`  in  32  new LFSR state.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is left.
- `done`  out  1  one-cycle pulse when the final frame has been captured.
- `frame_idx`  out  $clog2(FRAME_COUNT+1)  count of frames completed in the current run.
- `signature`  out  32  MISR accumulation of the results.
- `operands`  out  [OPERAND_COUNT-1:0][OPERAND_WIDTH-1:0]  registered operand bus.
- `results`  in  [RESULT_COUNT-1:0][RESULT_WIDTH-1:0]  result bus from the experiment.

Behaviour:
- Reset values (async, immediate):
  - state = IDLE; `busy`, `done`, `frame_idx`, `signature`, `operands` = 0.
  - lfsr = LFSR_SEED. A seed of 0 is replaced by 1.
  - wait counter = 0.
- LFSR:
  - Galois, polynomial x^32+x^22+x^2+x+1.
  - Step: `lfsr <= lfsr[0] ? (lfsr>>1) ^ 32'h80200003 : lfsr>>1`.
  - `seed_load` in IDLE: lfsr <= (seed==0) ? 1 : seed. `seed_load` takes priority over `start` in the same cycle; `start` is then ignored.
- Operand mapping:
  - Word k = {lfsr rotated left by 8*k}, truncated or zero-extended to OPERAND_WIDTH.
  - Registered. Stable for the whole frame.
- States:
  - IDLE:
    - On `start` and not `seed_load`: go to DRIVE; `frame_idx` <= 0; `signature` <= 0.
  - DRIVE (1 cycle):
    - `operands` <= mapping(lfsr); lfsr steps once; wait counter <= LATENCY.
    - Next state: WAIT if LATENCY>0, else CAPTURE.
  - WAIT:
    - Decrement the counter each cycle; go to CAPTURE when the counter reaches 1.
    - Result: exactly LATENCY cycles in WAIT.
  - CAPTURE (1 cycle):
    - fold = XOR of all result words, each truncated or zero-extended to 32 bits.
    - `signature` <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ fold.
    - `frame_idx`++.
    - Go to DRIVE if `frame_idx`+1 < FRAME_COUNT, else go to DONE.
  - DONE (1 cycle):
    - `done`=1, then go to IDLE.
- Timing:
  - `results` are sampled on the (LATENCY+1)th rising edge after the edge that updated `operands`.
  - Frame period = LATENCY+2 cycles.
  - Run length = FRAME_COUNT*(LATENCY+2)+1 cycles from `start` accepted to `done`.
- Inputs outside IDLE: `start` and `seed_load` are ignored; the run is never restarted mid-run.
- Signature and `frame_idx` hold their final values in IDLE until the next accepted `start`.
- LFSR continuity: the LFSR is not re-seeded between runs. Consecutive runs produce new patterns unless `seed_load` is used.
- `rst` mid-run: abort immediately to reset values. No `done` pulse.

Optional Feature:
- Macro: `EXPERIMENT_DRIVER_CONTINUOUS_EN`.
- Defined:
  - DONE goes back to DRIVE when `start` is still high. `frame_idx` and `signature` are cleared for the new batch, and `done` pulses once per batch.
  - DONE goes to IDLE when `start` is low.
  - `busy` stays high across batches.
- Undefined: DONE always goes to IDLE. Another run needs `start` sampled again in IDLE.

Decomposition:
- Shared package `experiment_pkg`:
  - state enum `drv_state_t` {IDLE, DRIVE, WAIT, CAPTURE, DONE};
  - constants `LFSR_POLY` = 32'h80200003 and `MISR_TAPS`;
  - function `lfsr_step`.
- One sub-module: `lfsr32` (seedable Galois LFSR with step/load enables). FSM, counter and MISR stay in `experiment_driver`.

Test Plan:
1. Reset with defaults: `busy`=0, `done`=0, `signature`=0, `operands`=0. After `seed_load` with seed=0, the first DRIVE gives operands[0]=32'h00000001 and operands[1]=32'h00000100.
2. LATENCY=4, FRAME_COUNT=16, `results` tied to 0 → `done` 97 cycles after `start` accepted. `signature`=0, `frame_idx`=16, `busy` low the cycle after `done`.
3. LATENCY=0, results = echo of operands[0] delayed 1 cycle → capture matches the current frame's operands. `signature` equals the reference-model MISR of the 16 LFSR values starting from seed 1.
4. Assert `start` and `seed_load` mid-run → no effect: identical `signature` and `done` timing to scenario 3. `seed_load` and `start` together in IDLE → seed loaded, run not started.
5. `rst` pulse during WAIT of frame 5 → all outputs 0 asynchronously, no `done`, lfsr=LFSR_SEED; the next run matches a fresh run.
6. `EXPERIMENT_DRIVER_CONTINUOUS_EN` defined, `start` held high → `done` pulses every FRAME_COUNT*(LATENCY+2)+1 cycles, `busy` stays high; dropping `start` → IDLE after the current batch.
